nand_flash_reader: RTL

Page-read master for the small-page NAND used by the flash programming path; the read-back counterpart of the page writer.
- Issues Read (00h) plus three address cycles per page, waits out tR on F_RB_B, then clocks PAGE_BYTES bytes out with F_REN_B pulses.
- Delivers bytes on a valid/ready stream. Walks pages 0..NUM_PAGES-1 sequentially, column 0, then signals done.

---
 rtl/nand_flash_reader.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/nand_flash_reader.sv
// rtl/nand_flash_reader.sv - sequential NAND page-read master with valid/ready byte output
// Optional NAND_RD_CHECKSUM_EN adds per-page XOR (page_xor) and last-byte strobe (page_end).
module nand_flash_reader #(
  parameter int PAGE_BYTES = 512,
  parameter int NUM_PAGES  = 512,
  parameter int BUSY_WAIT  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       F_RB_B,
  inout  wire  [7:0] F_IO_B,
  output logic       F_CLE_B,
  output logic       F_ALE_B,
  output logic       F_REN_B,
  output logic       F_WEN_B,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       done
`ifdef NAND_RD_CHECKSUM_EN
  ,
  output logic [7:0] page_xor,
  output logic       page_end
`endif
);

  localparam int BW = (PAGE_BYTES > 1) ? $clog2(PAGE_BYTES) : 1;
  localparam int WW = $clog2(BUSY_WAIT) + 1;

  typedef enum logic [3:0] {
    IDLE, CMD_L, CMD_H, ADDR0_L, ADDR0_H, ADDR1_L, ADDR1_H, ADDR2_L, ADDR2_H,
    WAIT_BSY, WAIT_RDY, RD_L1, RD_L2, OUT, DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [8:0]      r_page;
  logic [BW-1:0]   r_byte;
  logic [WW-1:0]   r_wait;
  logic [7:0]      r_data;

  logic       w_cle, w_ale, w_ren, w_wen, w_oe, w_valid, w_done;
  logic [7:0] w_io;
  logic       w_accept, w_last_byte, w_last_page;

  assign w_accept    = (r_state == OUT) && data_ready;
  assign w_last_byte = (r_byte == BW'(PAGE_BYTES - 1));
  assign w_last_page = (r_page == 9'(NUM_PAGES - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_page  <= '0;
      r_byte  <= '0;
      r_wait  <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ADDR2_H)
        r_wait <= '0;
      else if (r_state == WAIT_BSY)
        r_wait <= r_wait + 1'b1;
      if (r_state == RD_L2)
        r_data <= F_IO_B;
      if (r_state == IDLE) begin
        r_page <= '0;
        r_byte <= '0;
      end else if (w_accept) begin
        if (w_last_byte) begin
          r_byte <= '0;
          r_page <= r_page + 1'b1;
        end else begin
          r_byte <= r_byte + 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_next  = r_state;
    w_cle   = 1'b0;
    w_ale   = 1'b0;
    w_ren   = 1'b1;
    w_wen   = 1'b1;
    w_oe    = 1'b0;
    w_io    = 8'h00;
    w_valid = 1'b0;
    w_done  = 1'b0;
    unique case (r_state)
      IDLE:    if (en) w_next = CMD_L;
      CMD_L:   begin w_cle = 1'b1; w_wen = 1'b0; w_oe = 1'b1; w_next = CMD_H; end
      CMD_H:   begin w_cle = 1'b1; w_oe = 1'b1; w_next = ADDR0_L; end
      // Column is always 0, so the low address byte is constant zero.
      ADDR0_L: begin w_ale = 1'b1; w_wen = 1'b0; w_oe = 1'b1; w_next = ADDR0_H; end
      ADDR0_H: begin w_ale = 1'b1; w_oe = 1'b1; w_next = ADDR1_L; end
      ADDR1_L: begin w_ale = 1'b1; w_wen = 1'b0; w_oe = 1'b1; w_io = r_page[7:0]; w_next = ADDR1_H; end
      ADDR1_H: begin w_ale = 1'b1; w_oe = 1'b1; w_io = r_page[7:0]; w_next = ADDR2_L; end
      ADDR2_L: begin w_ale = 1'b1; w_wen = 1'b0; w_oe = 1'b1; w_io = {7'b0, r_page[8]}; w_next = ADDR2_H; end
      ADDR2_H: begin w_ale = 1'b1; w_oe = 1'b1; w_io = {7'b0, r_page[8]}; w_next = WAIT_BSY; end
      WAIT_BSY: if (!F_RB_B || (r_wait == WW'(BUSY_WAIT - 1))) w_next = WAIT_RDY;
      WAIT_RDY: if (F_RB_B) w_next = RD_L1;
      RD_L1:   begin w_ren = 1'b0; w_next = RD_L2; end
      RD_L2:   begin w_ren = 1'b0; w_next = OUT; end
      OUT: begin
        w_valid = 1'b1;
        if (data_ready) begin
          if (!w_last_byte)     w_next = RD_L1;
          else if (w_last_page) w_next = DONE;
          else                  w_next = CMD_L;
        end
      end
      DONE: begin
        w_done = 1'b1;
        if (!en) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Outputs fall to idle levels combinationally in any cycle reset is held.
  assign F_CLE_B    = rst & w_cle;
  assign F_ALE_B    = rst & w_ale;
  assign F_REN_B    = ~rst | w_ren;
  assign F_WEN_B    = ~rst | w_wen;
  assign F_IO_B     = (rst && w_oe) ? w_io : 8'hzz;
  assign data_out   = rst ? r_data : 8'h00;
  assign data_valid = rst & w_valid;
  assign done       = rst & w_done;

`ifdef NAND_RD_CHECKSUM_EN
  logic [7:0] r_xor;
  logic       r_pend;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_xor  <= '0;
      r_pend <= 1'b0;
    end else begin
      r_pend <= w_accept && w_last_byte;
      if (r_state == CMD_L)
        r_xor <= '0;
      else if (w_accept)
        r_xor <= r_xor ^ r_data;
    end
  end

  assign page_xor = rst ? r_xor : 8'h00;
  assign page_end = rst & r_pend;
`endif

endmodule
